// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned HEADER_BYTES   = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CHK_WIDTH      = 8;

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word and flags it
// with a one-cycle registered word_valid when the last lane lands.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_lane,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_lanes;
  logic [1:0]  r_lane;
  logic        r_word_valid;
  logic [31:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lanes      <= '0;
      r_lane       <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_lanes <= '0;
        r_lane  <= '0;
        r_word  <= '0;
      end else if (i_valid) begin
        if (r_lane == LAST_LANE) begin
          r_word       <= {i_byte, r_lanes};
          r_word_valid <= 1'b1;
          r_lanes      <= '0;
          r_lane       <= '0;
        end else begin
          r_lanes[{r_lane, 3'b000} +: 8] <= i_byte;
          r_lane                         <= r_lane + 2'd1;
        end
      end
    end
  end

  assign o_lane       = r_lane;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed byte stream into program memory,
// verifies an 8-bit checksum and only then releases the core from reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [31:0]           mem_data_o,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  error_o
);

  state_t                r_state;
  logic                  r_ready;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
  logic [15:0]           r_len;
  logic [15:0]           r_word_cnt;
  logic [CHK_WIDTH-1:0]  r_chk;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_accept;
  logic                  w_can_start;
  logic                  w_clear;
  logic                  w_data_accept;
  logic [15:0]           w_len;
  logic [1:0]            w_lane;
  logic                  w_word_valid;
  logic [31:0]           w_word;

  assign w_accept      = byte_valid_i & r_ready;
  assign w_can_start   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_clear       = w_can_start & start_i;
  assign w_data_accept = w_accept & (r_state == ST_DATA);
  assign w_len         = {byte_data_i, r_len[7:0]};

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (reset),
    .i_clear      (w_clear),
    .i_valid      (w_data_accept),
    .i_byte       (byte_data_i),
    .o_lane       (w_lane),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_chk       <= '0;
      r_addr      <= '0;
    end else begin
      // Address advances the edge after the write strobe; the word counter has
      // already moved on, so the final word leaves the address in range.
      if (w_word_valid && (r_word_cnt < r_len))
        r_addr <= r_addr + ADDR_WIDTH'(1);

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            r_state     <= ST_LEN_LO;
            r_ready     <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_chk       <= '0;
            r_addr      <= '0;
          end
        end
        ST_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= byte_data_i;
            r_state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len;
            if (32'(w_len) > 32'(MEMORY_DEPTH)) begin
              r_state <= ST_ERROR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_chk <= r_chk + byte_data_i;
            if (w_lane == LAST_LANE) begin
              r_word_cnt <= r_word_cnt + 16'd1;
              if (r_word_cnt == r_len - 16'd1)
                r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (byte_data_i == r_chk) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o  = r_ready;
  assign mem_write_o   = w_word_valid;
  assign mem_address_o = r_addr;
  assign mem_data_o    = w_word;
  assign cpu_reset_o   = r_cpu_reset;
  assign done_o        = r_done;
  assign error_o       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes and
// load outcomes; a negedge monitor pops and compares as the DUT reports them.
module tb_program_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic          start_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_address_o;
  logic [31:0]   mem_data_o;
  logic          cpu_reset_o;
  logic          done_o;
  logic          error_o;

  program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .byte_valid_i  (byte_valid_i),
    .byte_data_i   (byte_data_i),
    .byte_ready_o  (byte_ready_o),
    .mem_write_o   (mem_write_o),
    .mem_address_o (mem_address_o),
    .mem_data_o    (mem_data_o),
    .cpu_reset_o   (cpu_reset_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic done;
    logic error;
    logic cpu_reset;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write strobe and every rising done/error.
  initial begin
    logic prev_done, prev_err;
    wr_t  w;
    res_t r;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_write_o === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_address_o, mem_data_o);
        end else begin
          w = wr_q.pop_front();
          check("write_addr", 32'(mem_address_o), 32'(w.addr));
          check("write_data", mem_data_o, w.data);
        end
      end
      if ((done_o === 1'b1 && !prev_done) || (error_o === 1'b1 && !prev_err)) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_outcome: done %0b error %0b, expected none", done_o, error_o);
        end else begin
          r = res_q.pop_front();
          check("outcome", {29'd0, done_o, error_o, cpu_reset_o}, {29'd0, r.done, r.error, r.cpu_reset});
        end
      end
      prev_done = (done_o === 1'b1);
      prev_err  = (error_o === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    check("ready_after_start", {31'd0, byte_ready_o}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Offers a byte until a handshake edge, returning at that edge + 1.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc          = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = byte_ready_o;
    end
    check("byte_accepted", {31'd0, acc}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input logic d, input logic e);
    res_t r;
    r.done      = d;
    r.error     = e;
    r.cpu_reset = ~d;
    res_q.push_back(r);
  endtask

  task automatic check_outcome_now(input string name, input logic d, input logic e);
    @(negedge clk);
    check(name, {29'd0, done_o, error_o, cpu_reset_o}, {29'd0, d, e, ~d});
    check({name, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_two_word_stream(input logic [7:0] chk);
    logic [7:0] bytes [10];
    bytes = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h50, 8'h09, 8'h01};
    wr_q.push_back('{addr: AW'(0), data: 32'h2008_0005});
    wr_q.push_back('{addr: AW'(1), data: 32'h0109_5020});
    for (int i = 0; i < 10; i++) send_byte(bytes[i]);
    send_byte(chk);
  endtask

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready",     {31'd0, byte_ready_o}, 32'd0);
    check("rst_write",     {31'd0, mem_write_o},  32'd0);
    check("rst_addr",      32'(mem_address_o),    32'd0);
    check("rst_data",      mem_data_o,            32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset_o},  32'd1);
    check("rst_done",      {31'd0, done_o},       32'd0);
    check("rst_error",     {31'd0, error_o},      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) gap();
    @(negedge clk);
    check("idle_ready", {31'd0, byte_ready_o}, 32'd0);
    @(posedge clk);
    #1;

    // Two-word program; payload bytes sum to 0xA7.
    do_start();
    expect_result(1'b1, 1'b0);
    send_two_word_stream(8'hA7);
    check_outcome_now("good_chk", 1'b1, 1'b0);

    do_start();
    expect_result(1'b0, 1'b1);
    send_two_word_stream(8'hA6);
    check_outcome_now("bad_chk", 1'b0, 1'b1);

    // Length 65 exceeds the 64-word memory.
    do_start();
    expect_result(1'b0, 1'b1);
    send_byte(8'h41);
    send_byte(8'h00);
    check_outcome_now("overlength", 1'b0, 1'b1);
    repeat (3) gap();
    @(negedge clk);
    check("overlength_ready_held", {31'd0, byte_ready_o}, 32'd0);
    @(posedge clk);
    #1;

    // Empty program.
    do_start();
    expect_result(1'b1, 1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_outcome_now("empty", 1'b1, 1'b0);

    // One word with a bubble between every byte; 78+56+34+12 = 0x114.
    do_start();
    expect_result(1'b1, 1'b0);
    wr_q.push_back('{addr: AW'(0), data: 32'h1234_5678});
    send_byte(8'h01); gap();
    send_byte(8'h00); gap();
    send_byte(8'h78); gap();
    send_byte(8'h56); gap();
    send_byte(8'h34); gap();
    send_byte(8'h12);
    @(negedge clk);
    check("write_latency", {31'd0, mem_write_o}, 32'd1);
    @(negedge clk);
    check("write_one_cycle", {31'd0, mem_write_o}, 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h14);
    check_outcome_now("gapped", 1'b1, 1'b0);

    // Reset in the middle of a word, then reload.
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("midrst_ready",     {31'd0, byte_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    gap();
    do_start();
    expect_result(1'b1, 1'b0);
    wr_q.push_back('{addr: AW'(0), data: 32'h4433_2211});
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'hAA);
    check_outcome_now("after_reset", 1'b1, 1'b0);

    repeat (4) gap();
    check("writes_pending",   32'(wr_q.size()),  32'd0);
    check("outcomes_pending", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
